sensor_poll_scheduler: RTL
==========================

Name: sensor_poll_scheduler

Overview:
- Bus-visible controller that sequences an external byte UART to poll up to NUM_SENSORS sensors round-robin.
- Per sensor: sends the sensor ID byte, receives a data byte and a CRC-8 byte, checks the CRC, and retries on CRC error or timeout.
- Latches a per-sensor result register and maintains error statistics.
- Sits between the Avalon-style slave bus and the uart instance, which it drives through that instance's din/wr_en/tx_busy/rdy/rdy_clr/dout handshake.

Parameters:
NUM_SENSORS, 5, sensors polled, IDs 1..NUM_SENSORS; legal range 1..6.
TIMEOUT_CYCLES, 50000, clock cycles allowed per received byte.
MAX_RETRY, 3, attempts per sensor before it is marked faulted; range 1..3.
TMR_W, 16, width of the timeout counter.

Ports:
clock  in  1  system clock.
resetn  in  1  reset, asynchronous, active-low.
chip_select  in  1  slave select.
read  in  1  read strobe, qualified by chip_select.
write  in  1  write strobe, qualified by chip_select.
address  in  3  register index.
writedata  in  32  write data.
readdata  out  32  read data, registered.
uart_din  out  8  byte to transmit.
uart_wr_en  out  1  one-cycle transmit request.
uart_tx_busy  in  1  UART transmitter busy.
uart_dout  in  8  received byte.
uart_rdy  in  1  received byte valid.
uart_rdy_clr  out  1  one-cycle acknowledge of the received byte.

Behaviour:
- Reset (async, resetn low): all outputs 0; FSM to IDLE; sensor index = 1; retry = 0; enable = 0; results and statistics = 0. Reset mid-transaction abandons the transaction with no register update.
- Register map:
  - addr 0 write: bit0 = enable, bit1 = clear_all (self-clearing).
  - addr 0 read: {16'b0, fault bitmap[7:0], 1'b0, state[3:0], sensor_idx[2:0]}.
  - addr 1..NUM_SENSORS read: {valid[31], fault[30], 4'b0, attempts[25:24], 8'b0, crc[15:8], data[7:0]}.
  - addr 7 read: {timeouts[31:16], crc_errors[15:0]}; both counters saturate at 0xFFFF.
  - Unmapped reads return 0; writes to any address other than 0 are ignored.
- readdata latency: 1 cycle after chip_select&read.
- CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, computed over the data byte only.
- FSM states and transitions:
  - IDLE: if enable -> SEND.
  - SEND: wait while uart_tx_busy. When not busy, drive uart_din = {5'b0, sensor_idx}, pulse uart_wr_en for exactly 1 cycle, clear timer, -> RX_DATA.
  - RX_DATA: on uart_rdy (ignored in any cycle where uart_rdy_clr is high), capture data, pulse uart_rdy_clr 1 cycle (registered), clear timer, -> RX_CRC. If timer == TIMEOUT_CYCLES-1 -> FAIL (timeout).
  - RX_CRC: same capture and timeout rules, capturing the crc byte; -> CHECK.
  - CHECK: if crc matches, write the result (valid=1, fault=0, attempts = retry+1), retry = 0, -> NEXT. Otherwise crc_errors++ and -> FAIL.
  - FAIL: timeouts++ if entered by timeout. Then retry++. If retry+1 == MAX_RETRY: write the result (valid=0, fault=1, attempts, data/crc = last captured values), retry = 0, -> NEXT. Otherwise -> SEND with the same sensor.
  - NEXT: sensor_idx wraps NUM_SENSORS -> 1, else +1. Then -> SEND if enable, else -> IDLE.
- Clearing enable mid-transaction: the current sensor completes (including its retries), then the FSM goes to IDLE.
- clear_all in the same cycle as a result write: clear_all wins; the result is lost and the statistics are zeroed.
- uart_rdy arriving in SEND or IDLE: ignored; not acknowledged.
- Fault bitmap bit i-1 mirrors the fault bit of sensor i.

Test Plan:
- Enable with NUM_SENSORS=2; sensor replies 0x01,0x07 -> uart_din=0x01 then 0x02; addr1 reads 0x81000701 (valid, attempts=1); addr2 follows the same pattern.
- Sensor 1 replies 0x80,0x00, then 0x80,0x89 -> addr7 crc_errors=1; addr1 reads 0x82008980.
- TIMEOUT_CYCLES=100, no reply -> 3 attempts spaced at ~100 cycles each; addr1 fault=1, valid=0; addr7 timeouts=3; status fault bitmap bit0=1; polling advances to sensor 2.
- uart_tx_busy held high for 20 cycles in SEND -> uart_wr_en stays 0 until busy drops, then a single 1-cycle pulse.
- Clear enable during RX_DATA -> the transaction completes, FSM returns to IDLE, and no further uart_wr_en occurs. Assert resetn low mid-RX_CRC -> all outputs 0 immediately; registers read 0 after release.
- Assert clear_all in the same cycle as a CHECK result write -> addr1 reads 0 and addr7 reads 0.

Source files
------------

// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: round-robin sensor poller driving a byte UART,
// with CRC-8 checking, retries, per-sensor results and error statistics.
module sensor_poll_scheduler #(
   parameter int NUM_SENSORS    = 5,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRY      = 3,
   parameter int TMR_W          = 16
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        chip_select,
   input  logic        read,
   input  logic        write,
   input  logic [2:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  uart_din,
   output logic        uart_wr_en,
   input  logic        uart_tx_busy,
   input  logic [7:0]  uart_dout,
   input  logic        uart_rdy,
   output logic        uart_rdy_clr
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_SEND    = 4'd1,
      S_RX_DATA = 4'd2,
      S_RX_CRC  = 4'd3,
      S_CHECK   = 4'd4,
      S_FAIL    = 4'd5,
      S_NEXT    = 4'd6
   } state_e;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       RTY_LAST = 2'(MAX_RETRY - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_SENSORS);

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [1:0]       retry_q, retry_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       crc_q, crc_d;
   logic             tmo_q, tmo_d;
   logic [7:0]       din_q, din_d;
   logic             wr_en_q, wr_en_d;
   logic             rdy_clr_q, rdy_clr_d;
   logic             en_q;
   logic [31:0]      readdata_q;

   logic [NUM_SENSORS-1:0] valid_q;
   logic [NUM_SENSORS-1:0] fault_q;
   logic [1:0]             att_q [NUM_SENSORS];
   logic [7:0]             rdat_q [NUM_SENSORS];
   logic [7:0]             rcrc_q [NUM_SENSORS];
   logic [15:0]            crc_err_q;
   logic [15:0]            tmo_cnt_q;

   logic        res_we;
   logic        res_valid;
   logic        res_fault;
   logic [1:0]  res_att;
   logic        crc_inc;
   logic        tmo_inc;
   logic        rx_ok;
   logic        timer_end;
   logic        wr0;
   logic        clear_all;
   logic [7:0]  fault_map;
   logic [31:0] rd_mux;
   logic        unused_wd;

   function automatic logic [7:0] crc8(input logic [7:0] d);
      logic [7:0] c;
      c = d;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   assign wr0       = chip_select & write & (address == 3'd0);
   assign clear_all = wr0 & writedata[1];
   assign unused_wd = ^writedata[31:2];

   // A byte still flagged while its acknowledge is in flight is the old one.
   assign rx_ok     = uart_rdy & ~rdy_clr_q;
   assign timer_end = (timer_q == TMR_LAST);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      timer_d   = timer_q;
      data_d    = data_q;
      crc_d     = crc_q;
      tmo_d     = tmo_q;
      din_d     = din_q;
      wr_en_d   = 1'b0;
      rdy_clr_d = 1'b0;
      res_we    = 1'b0;
      res_valid = 1'b0;
      res_fault = 1'b0;
      res_att   = retry_q + 2'd1;
      crc_inc   = 1'b0;
      tmo_inc   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (en_q) state_d = S_SEND;
         end
         S_SEND: begin
            if (!uart_tx_busy) begin
               din_d   = {5'b0, idx_q};
               wr_en_d = 1'b1;
               timer_d = '0;
               state_d = S_RX_DATA;
            end
         end
         S_RX_DATA: begin
            if (rx_ok) begin
               data_d    = uart_dout;
               rdy_clr_d = 1'b1;
               timer_d   = '0;
               state_d   = S_RX_CRC;
            end else if (timer_end) begin
               tmo_d   = 1'b1;
               state_d = S_FAIL;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_RX_CRC: begin
            if (rx_ok) begin
               crc_d     = uart_dout;
               rdy_clr_d = 1'b1;
               timer_d   = '0;
               state_d   = S_CHECK;
            end else if (timer_end) begin
               tmo_d   = 1'b1;
               state_d = S_FAIL;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_CHECK: begin
            if (crc8(data_q) == crc_q) begin
               res_we    = 1'b1;
               res_valid = 1'b1;
               retry_d   = 2'd0;
               state_d   = S_NEXT;
            end else begin
               crc_inc = 1'b1;
               tmo_d   = 1'b0;
               state_d = S_FAIL;
            end
         end
         S_FAIL: begin
            tmo_inc = tmo_q;
            if (retry_q == RTY_LAST) begin
               res_we    = 1'b1;
               res_fault = 1'b1;
               retry_d   = 2'd0;
               state_d   = S_NEXT;
            end else begin
               retry_d = retry_q + 2'd1;
               state_d = S_SEND;
            end
         end
         S_NEXT: begin
            idx_d   = (idx_q == IDX_LAST) ? 3'd1 : idx_q + 3'd1;
            state_d = en_q ? S_SEND : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         idx_q     <= 3'd1;
         retry_q   <= 2'd0;
         timer_q   <= '0;
         data_q    <= 8'd0;
         crc_q     <= 8'd0;
         tmo_q     <= 1'b0;
         din_q     <= 8'd0;
         wr_en_q   <= 1'b0;
         rdy_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         timer_q   <= timer_d;
         data_q    <= data_d;
         crc_q     <= crc_d;
         tmo_q     <= tmo_d;
         din_q     <= din_d;
         wr_en_q   <= wr_en_d;
         rdy_clr_q <= rdy_clr_d;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         en_q <= 1'b0;
      end else if (wr0) begin
         en_q <= writedata[0];
      end
   end

   // clear_all takes priority over a result landing in the same cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         fault_q <= '0;
         for (int i = 0; i < NUM_SENSORS; i++) begin
            att_q[i]  <= 2'd0;
            rdat_q[i] <= 8'd0;
            rcrc_q[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_SENSORS; i++) begin
            if (clear_all) begin
               valid_q[i] <= 1'b0;
               fault_q[i] <= 1'b0;
               att_q[i]   <= 2'd0;
               rdat_q[i]  <= 8'd0;
               rcrc_q[i]  <= 8'd0;
            end else if (res_we && idx_q == 3'(i + 1)) begin
               valid_q[i] <= res_valid;
               fault_q[i] <= res_fault;
               att_q[i]   <= res_att;
               rdat_q[i]  <= data_q;
               rcrc_q[i]  <= crc_q;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         crc_err_q <= 16'd0;
         tmo_cnt_q <= 16'd0;
      end else if (clear_all) begin
         crc_err_q <= 16'd0;
         tmo_cnt_q <= 16'd0;
      end else begin
         if (crc_inc && crc_err_q != 16'hFFFF) begin
            crc_err_q <= crc_err_q + 16'd1;
         end
         if (tmo_inc && tmo_cnt_q != 16'hFFFF) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      fault_map                  = 8'd0;
      fault_map[NUM_SENSORS-1:0] = fault_q;
   end

   always_comb begin
      rd_mux = 32'd0;
      unique case (1'b1)
         (address == 3'd0): begin
            rd_mux = {16'b0, fault_map, 1'b0, state_q, idx_q};
         end
         (address == 3'd7): begin
            rd_mux = {tmo_cnt_q, crc_err_q};
         end
         default: begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
               if (address == 3'(i + 1)) begin
                  rd_mux = {valid_q[i], fault_q[i], 4'b0, att_q[i],
                            8'b0, rcrc_q[i], rdat_q[i]};
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         readdata_q <= 32'd0;
      end else if (chip_select && read) begin
         readdata_q <= rd_mux;
      end
   end

   assign readdata     = readdata_q;
   assign uart_din     = din_q;
   assign uart_wr_en   = wr_en_q;
   assign uart_rdy_clr = rdy_clr_q;

endmodule
